// File: rtl/nios_system_led_pkg.sv
// rtl/nios_system_led_pkg.sv - shared op codes, PIO addresses and FSM states for the LED arbiter
package nios_system_led_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [2:0] PIO_ADDR_DATA = 3'd0;
    localparam logic [2:0] PIO_ADDR_SET  = 3'd4;
    localparam logic [2:0] PIO_ADDR_CLR  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // PIO register targeted by each op; reserved never reaches the bus
    function automatic logic [2:0] op_to_addr(input logic [1:0] op);
        case (op)
            OP_SET:   op_to_addr = PIO_ADDR_SET;
            OP_CLEAR: op_to_addr = PIO_ADDR_CLR;
            default:  op_to_addr = PIO_ADDR_DATA;
        endcase
    endfunction

endpackage

// File: rtl/nios_system_rr_arb2.sv
// rtl/nios_system_rr_arb2.sv - two-way round-robin picker
module nios_system_rr_arb2
    import nios_system_led_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last,
    input  logic       en,
    output logic [1:0] grant,
    output logic       winner
);

    // Lone requester wins; on contention the one not served last wins
    always_comb begin
        winner = 1'b0;
        grant  = 2'b00;
        if (valid0 && valid1) begin
            winner = ~last;
        end else begin
            winner = valid1;
        end
        if (en) begin
            grant[0] = valid0 && !winner;
            grant[1] = valid1 && winner;
        end
    end

endmodule

// File: rtl/nios_system_led_arbiter.sv
// rtl/nios_system_led_arbiter.sv - round-robin share of the red-LED PIO write port with shadow copy
module nios_system_led_arbiter
    import nios_system_led_pkg::*;
#(
    parameter int DATA_W     = 18,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [DATA_W-1:0] req1_data,
    output logic [2:0]        pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [31:0]       pio_writedata,
    output logic [DATA_W-1:0] led_shadow,
    output logic              grant_id,
    output logic              busy,
    output logic              op_err
);

    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam bit         HAS_GAP  = (GAP_CYCLES > 0);

    state_t            state;
    state_t            state_nxt;
    logic              last;
    logic [7:0]        gap_cnt;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        grant;
    logic              winner;
    logic              accept;
    logic [1:0]        op_sel;
    logic [DATA_W-1:0] data_sel;

    nios_system_rr_arb2 u_arb (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .last   (last),
        .en     (state == ST_IDLE),
        .grant  (grant),
        .winner (winner)
    );

    assign accept     = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign op_sel     = winner ? req1_op : req0_op;
    assign data_sel   = winner ? req1_data : req0_data;
    assign busy       = (state != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one ISSUE cycle per grant, optional GAP before the next grant
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = HAS_GAP ? ST_GAP : ST_IDLE;
            ST_GAP:   if (gap_cnt == 8'd0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, registered bus strobes, shadow update and gap counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_address    <= 3'd0;
            pio_writedata  <= 32'd0;
            led_shadow     <= '0;
            grant_id       <= 1'b0;
            op_err         <= 1'b0;
            gap_cnt        <= 8'd0;
            last           <= 1'b1;
            op_q           <= OP_WRITE;
            data_q         <= '0;
        end else begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            op_err         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= op_sel;
                        data_q   <= data_sel;
                        grant_id <= winner;
                        last     <= winner;
                        if (op_sel == OP_RSVD) begin
                            op_err <= 1'b1;
                        end else begin
                            pio_chipselect <= 1'b1;
                            pio_write_n    <= 1'b0;
                            pio_address    <= op_to_addr(op_sel);
                            pio_writedata  <= 32'(data_sel);
                        end
                    end
                end
                ST_ISSUE: begin
                    case (op_q)
                        OP_WRITE: led_shadow <= data_q;
                        OP_SET:   led_shadow <= led_shadow | data_q;
                        OP_CLEAR: led_shadow <= led_shadow & ~data_q;
                        default:  led_shadow <= led_shadow;
                    endcase
                    gap_cnt <= GAP_LOAD;
                end
                ST_GAP: begin
                    if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/nios_system_led_arbiter.md
Name: nios_system_led_arbiter

Overview:
- Shares the 18-bit red-LED PIO write port between two requesters: req0 is the Nios software mailbox and req1 is the accelerator status path.
- Arbitrates round-robin and converts each accepted request into a single Avalon write to the PIO. The write targets the data, set or clear register, depending on the op.
- Keeps a shadow copy of the PIO output value, so requesters see the current LED state without a read transaction.
- Sits between the requesters and the PIO s1 slave.

Parameters:
- DATA_W, 18, LED/PIO data width. Must be no more than 32.
- GAP_CYCLES, 0, idle cycles inserted after each bus write before the next grant. Range 0-255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_op  in  2  00 = WRITE, 01 = SET, 10 = CLEAR, 11 = reserved
- req0_data  in  DATA_W  operand
- req1_valid / req1_ready / req1_op / req1_data  same as the req0 ports
- pio_address  out  3  PIO register address
- pio_chipselect  out  1  PIO chipselect
- pio_write_n  out  1  PIO write strobe, active low
- pio_writedata  out  32  PIO write data
- led_shadow  out  DATA_W  mirror of the PIO output value
- grant_id  out  1  requester of the most recent accepted request
- busy  out  1  high in any state other than IDLE
- op_err  out  1  one-cycle pulse when a reserved op is accepted

Behaviour:
- Clocking and reset: one clock (clk). reset_n is asynchronous and active-low. Reset takes effect immediately, even mid-operation, and forces:
  - state = IDLE
  - pio_chipselect = 0, pio_write_n = 1, pio_address = 0, pio_writedata = 0
  - led_shadow = 0, matching the PIO reset value
  - grant_id = 0, op_err = 0, gap counter = 0
  - round-robin pointer last = 1, so req0 wins the first contention
- A write in flight at reset is abandoned.
- FSM states: IDLE, ISSUE, GAP.
- IDLE:
  - The readys are combinational from state and valids. They are high only in IDLE, and only for the winner.
  - Winner selection: if only one requester is valid, it wins. If both are valid, the winner is the requester that is not `last`.
  - On a grant (valid && ready): latch op and data, set grant_id = winner and last = winner, then go to ISSUE.
  - With no valid requester, stay in IDLE.
- ISSUE lasts exactly one cycle:
  - pio_chipselect = 1 and pio_write_n = 0.
  - Address: WRITE uses 0, SET uses 4, CLEAR uses 5.
  - pio_writedata = latched data, zero-extended to 32 bits.
  - On the closing edge, update led_shadow: WRITE gives data, SET gives shadow | data, CLEAR gives shadow & ~data.
  - Next state: GAP if GAP_CYCLES > 0, otherwise IDLE.
- Reserved op 11: no bus write is performed. chipselect stays 0, the shadow is unchanged, and op_err pulses during the ISSUE cycle. The request still counts as granted for round-robin.
- GAP:
  - The counter loads GAP_CYCLES-1 on entry and decrements each cycle.
  - Leave for IDLE when the counter reaches 0, so GAP lasts exactly GAP_CYCLES cycles.
  - Readys stay low throughout.
- Bus outputs are registered. Outside ISSUE: chipselect = 0, write_n = 1, and address and writedata hold their last values.
- Latency: a request accepted at cycle N is written on the bus at N+1. The new led_shadow value is visible at N+2.
- Throughput: one write every 2+GAP_CYCLES cycles. Two continuously valid requesters alternate strictly.
- Requesters must hold valid, op and data stable until ready is seen. The block samples them only in the accept cycle.
- Simultaneous WRITE/SET/CLEAR from both requesters are serialized, and the shadow follows the issue order.

Decomposition:
- Shared package nios_system_led_pkg holds:
  - op encoding constants: OP_WRITE, OP_SET, OP_CLEAR, OP_RSVD
  - PIO address constants: PIO_ADDR_DATA = 0, PIO_ADDR_SET = 4, PIO_ADDR_CLR = 5
  - the state enum
- Sub-module: nios_system_rr_arb2, a two-way round-robin picker. Inputs are the valids, last and en. Outputs are the one-hot grant and winner id. Everything else stays in the top module.

Test Plan:
- Reset, then req0 WRITE 0x2AAAA: bus shows address 0, writedata 0x0002AAAA with write_n low for exactly 1 cycle; led_shadow = 0x2AAAA two cycles after accept; grant_id = 0.
- From shadow 0x00F0F, req1 SET 0x30000 then req1 CLEAR 0x0000F: addresses 4 then 5; led_shadow becomes 0x30F0F, then 0x30F00.
- Both valid continuously with GAP_CYCLES = 0: grants go 0, 1, 0, 1; one bus write every 2 cycles; neither ready is high outside IDLE.
- GAP_CYCLES = 3, both valid: 3 idle cycles between writes; bus writes spaced exactly 5 cycles apart.
- req0 op 11 with data 0x3FFFF: op_err pulses once, no chipselect, shadow unchanged; the next contention is granted to req1.
- Assert reset_n low during ISSUE: chipselect drops and write_n goes high immediately, led_shadow = 0, state is IDLE; after release, the first contention goes to req0.
